// File: rtl/digit_entry_buffer.sv
// Six-digit keypad entry buffer with backspace, enter-to-judge, clear
// and an idle timeout that discards a partial entry.
module digit_entry_buffer #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [3:0] d4,
    output logic [3:0] d5,
    output logic [3:0] d6,
    output logic [2:0] count,
    output logic       full,
    output logic       j,
    output logic       err,
    output logic       busy
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ENTRY = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [3:0]  K_BKSP  = 4'hA;
    localparam logic [3:0]  K_ENTER = 4'hB;
    localparam logic [3:0]  K_CLEAR = 4'hC;
    localparam logic [19:0] T_LAST  = 20'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [3:0]  dig [6];
    logic [19:0] timer;
    logic        timed;

    assign timed = (state == S_ENTRY) || (state == S_FULL);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state <= S_EMPTY;
            count <= 3'd0;
            timer <= 20'd0;
            j     <= 1'b0;
            err   <= 1'b0;
            for (int i = 0; i < 6; i++) dig[i] <= 4'd0;
        end else begin
            j   <= 1'b0;
            err <= 1'b0;
            if (key_valid) begin
                timer <= 20'd0;
                if (key_code < 4'd10) begin
                    unique case (state)
                        S_EMPTY, S_ENTRY: begin
                            dig[count] <= key_code;
                            count      <= count + 3'd1;
                            state      <= (count == 3'd5) ? S_FULL : S_ENTRY;
                        end
                        S_FULL: err <= 1'b1;
                        S_HOLD: begin
                            // New entry starts over from a blank buffer
                            for (int i = 0; i < 6; i++)
                                dig[i] <= (i == 0) ? key_code : 4'd0;
                            count <= 3'd1;
                            state <= S_ENTRY;
                        end
                    endcase
                end else if (key_code == K_BKSP) begin
                    if (timed) begin
                        dig[count - 3'd1] <= 4'd0;
                        count <= count - 3'd1;
                        state <= (count == 3'd1) ? S_EMPTY : S_ENTRY;
                    end else begin
                        err <= 1'b1;
                    end
                end else if (key_code == K_ENTER) begin
                    if (state == S_FULL) begin
                        j     <= 1'b1;
                        state <= S_HOLD;
                    end else begin
                        err <= 1'b1;
                    end
                end else if (key_code == K_CLEAR) begin
                    for (int i = 0; i < 6; i++) dig[i] <= 4'd0;
                    count <= 3'd0;
                    state <= S_EMPTY;
                end
            end else if (timed) begin
                if (timer == T_LAST) begin
                    for (int i = 0; i < 6; i++) dig[i] <= 4'd0;
                    count <= 3'd0;
                    state <= S_EMPTY;
                    timer <= 20'd0;
                end else begin
                    timer <= timer + 20'd1;
                end
            end else begin
                timer <= 20'd0;
            end
        end
    end

    assign d1   = dig[0];
    assign d2   = dig[1];
    assign d3   = dig[2];
    assign d4   = dig[3];
    assign d5   = dig[4];
    assign d6   = dig[5];
    assign full = (count == 3'd6);
    assign busy = timed;

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Directed bench for digit_entry_buffer with a short idle timeout.
module tb_digit_entry_buffer;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [3:0] d1, d2, d3, d4, d5, d6;
    logic [2:0] count;
    logic       full, j, err, busy;

    int n_cmp = 0;
    int n_bad = 0;

    digit_entry_buffer #(.TIMEOUT(8)) dut (
        .clk(clk), .clr_n(clr_n), .key_valid(key_valid),
        .key_code(key_code),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
        .count(count), .full(full), .j(j), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    wire [23:0] digs = {d1, d2, d3, d4, d5, d6};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset with a key present: reset must win
        clr_n = 1'b0;
        key_valid = 1'b1;
        key_code = 4'h5;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_digs", 32'(digs), 0);
        chk("rst_flags", 32'({full, j, err, busy}), 0);
        clr_n = 1'b1;

        // Six digits, enter, hold
        press(4'h1);
        chk("first_key", 32'({count, d1, busy}), 32'({3'd1, 4'h1, 1'b1}));
        for (int k = 2; k <= 6; k++) press(4'(k));
        chk("six_digs", 32'(digs), 32'h123456);
        chk("six_full", 32'({count, full, busy, err}), 32'({3'd6, 3'b110}));
        press(4'hB);
        chk("enter_j", 32'({j, err, busy}), 32'b100);
        idle(1);
        chk("j_single", 32'(j), 0);
        chk("hold_digs", 32'(digs), 32'h123456);
        idle(10);
        chk("hold_untimed", 32'({digs, count}), 32'({24'h123456, 3'd6}));
        press(4'hB);
        chk("enter_hold", 32'({j, err}), 32'b01);
        press(4'hA);
        chk("bksp_hold", 32'({err, count}), 32'({1'b1, 3'd6}));
        press(4'h4);
        chk("hold_digit", 32'(digs), 32'h400000);
        chk("hold_digit_st", 32'({count, busy, err}), 32'({3'd1, 2'b10}));
        press(4'hC);
        chk("clear", 32'({digs, count, busy, err}), 0);

        // 9,8,7, backspace, enter
        press(4'h9);
        press(4'h8);
        press(4'h7);
        press(4'hA);
        chk("bksp_digs", 32'(digs), 32'h980000);
        chk("bksp_count", 32'(count), 2);
        press(4'hB);
        chk("enter_entry", 32'({j, err, count}), 32'({2'b01, 3'd2}));
        idle(1);
        chk("err_single", 32'({j, err}), 0);
        press(4'hC);
        press(4'hA);
        chk("bksp_empty", 32'({err, count, busy}), 32'({1'b1, 4'd0}));

        // Overfill, backspace from full, clear
        for (int k = 1; k <= 6; k++) press(4'(k));
        press(4'h0);
        chk("overfill", 32'({err, count}), 32'({1'b1, 3'd6}));
        chk("overfill_digs", 32'(digs), 32'h123456);
        press(4'hA);
        chk("bksp_full", 32'({digs, count, full}),
            32'({24'h123450, 3'd5, 1'b0}));
        press(4'hC);
        chk("clear2", 32'({digs, count, busy, err}), 0);
        press(4'hE);
        chk("ignored", 32'({count, busy, err}), 0);

        // Timeout at TIMEOUT=8
        press(4'h5);
        idle(7);
        chk("to_pre", 32'({count, busy}), 32'({3'd1, 1'b1}));
        idle(1);
        chk("to_clear", 32'({digs, count, busy, err}), 0);
        press(4'h5);
        idle(7);
        press(4'h3);
        chk("to_keywins", 32'({count, d1, d2}), 32'({3'd2, 4'h5, 4'h3}));
        idle(7);
        chk("to_reload", 32'(count), 2);

        // Reset mid-entry with an enter key present
        clr_n = 1'b0;
        key_valid = 1'b1;
        key_code = 4'hB;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        clr_n = 1'b1;
        chk("rst_mid", 32'({digs, count, full, j, err, busy}), 0);
        idle(1);
        chk("rst_after", 32'({j, err, count}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/digit_entry_buffer.md
DIGIT_ENTRY_BUFFER -- requirements
Module: digit_entry_buffer

Interface
REQ-001 Parameter: TIMEOUT, default 1000, idle cycles before a partial entry auto-clears (range 2..2^20-1).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 clr_n  input  1  reset, synchronous, active-low.
REQ-004 key_valid  input  1  one-cycle strobe marking key_code valid.
REQ-005 key_code  input  4  0x0-0x9 digit; 0xA backspace; 0xB enter; 0xC clear; 0xD-0xF ignored.
REQ-006 d1..d6  output  4 each  entered digits; d1 is the first digit keyed.
REQ-007 count  output  3  number of digits currently held, 0..6.
REQ-008 full  output  1  high when count==6.
REQ-009 j  output  1  one-cycle judge pulse on an accepted enter.
REQ-010 err  output  1  one-cycle pulse on a rejected key.
REQ-011 busy  output  1  high in ENTRY or FULL.

Function
REQ-012 FSM states: EMPTY, ENTRY (count 1..5), FULL (count 6), HOLD (post-enter, digits frozen).
REQ-013 A key is acted on only in a cycle with key_valid=1; at most one key per cycle.
REQ-014 Digit in EMPTY/ENTRY: written to position count+1, count increments next cycle; EMPTY->ENTRY; count reaching 6 -> FULL.
REQ-015 Digit in FULL: ignored, digits unchanged, err pulses next cycle.
REQ-016 Digit in HOLD: d1..d6 cleared to 0, digit written to d1, count=1, -> ENTRY.
REQ-017 Backspace in ENTRY/FULL: position count cleared to 0, count decrements; count reaching 0 -> EMPTY; FULL -> ENTRY.
REQ-018 Backspace in EMPTY or HOLD: no change, err pulses.
REQ-019 Enter in FULL: j pulses high exactly one cycle (the cycle after the key), -> HOLD; d1..d6 stay stable through and after the j cycle.
REQ-020 Enter in EMPTY/ENTRY/HOLD: j stays low, err pulses, state and digits unchanged.
REQ-021 Clear in any state: d1..d6=0, count=0, -> EMPTY; no err.
REQ-022 Codes 0xD-0xF: no state change, no err.
REQ-023 Idle timer: counts cycles without key_valid while in ENTRY or FULL; reloads to 0 on any key_valid or on leaving these states.
REQ-024 Timer reaching TIMEOUT-1: next cycle d1..d6=0, count=0, -> EMPTY; err does not pulse.
REQ-025 key_valid in the same cycle the timer would expire: key wins, timer reloads, no timeout clear.
REQ-026 HOLD and EMPTY are not timed; HOLD persists until a digit or clear key.
REQ-027 j and err are registered, never high together, never high longer than one cycle.
REQ-028 count, full and busy are consistent with state in every cycle (full==(count==6), busy==(state is ENTRY or FULL)).

Reset
REQ-029 clr_n=0 at a rising edge: d1..d6=0, count=0, full=0, j=0, err=0, busy=0, timer=0, state EMPTY.
REQ-030 Reset overrides any key in the same cycle; reset mid-entry discards the partial code with no j or err.
REQ-031 First key is accepted in the first cycle with clr_n=1.

Verification
REQ-032 Keys 1,2,3,4,5,6 then enter -> d1..d6=1..6, full=1 before enter, single j pulse, state HOLD, digits held.
REQ-033 Keys 9,8,7, backspace, enter -> count=2, d1=9, d2=8, d3=0, err pulse, j never high.
REQ-034 Six digits then digit 0 -> err pulse, d6 unchanged, count=6; then clear -> all zero, EMPTY.
REQ-035 TIMEOUT=8, key 5 then 7 idle cycles -> still count=1; 8th idle cycle -> count=0, EMPTY, no err; repeat with key on expiry cycle -> no clear.
REQ-036 HOLD after valid entry, key 4 -> d1=4, d2..d6=0, count=1, ENTRY.
REQ-037 clr_n low during ENTRY with key_valid=1 -> all outputs zero next cycle, no j/err.
